// File: rtl/pixel_ram_arbiter.sv
// Arbiter owning the single-port pixel RAM: CPU pixel writes share the port with
// a frame scan engine that streams pixels to the LED serializer.
`timescale 1ns/1ps
module pixel_ram_arbiter #(
  parameter int AW   = 6,
  parameter int DW   = 24,
  parameter int NPIX = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          frame_start,
  output logic          frame_busy,
  output logic          frame_done,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr_out,
  output logic [AW-1:0] ram_addr_in,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  typedef enum logic [2:0] {IDLE, FETCH, RDWAIT, LATCH, PRESENT} state_t;

  localparam logic [AW-1:0] LAST     = AW'(NPIX - 1);
  localparam logic          LG_READ  = 1'b0;
  localparam logic          LG_WRITE = 1'b1;

  state_t        state_q, state_d;
  logic [AW-1:0] scan_addr_q, scan_addr_d;
  logic          last_grant_q, last_grant_d;
  logic          ram_rw_q, ram_rw_d;
  logic [AW-1:0] ram_addr_out_q, ram_addr_out_d;
  logic [AW-1:0] ram_addr_in_q, ram_addr_in_d;
  logic [DW-1:0] ram_data_in_q, ram_data_in_d;
  logic          wr_ack_q, wr_ack_d;
  logic          pix_valid_q, pix_valid_d;
  logic [DW-1:0] pix_data_q, pix_data_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_busy_q, frame_busy_d;
  logic          wr_elig;
  logic          grant;

  always_comb begin
    state_d        = state_q;
    scan_addr_d    = scan_addr_q;
    last_grant_d   = last_grant_q;
    ram_addr_out_d = ram_addr_out_q;
    ram_addr_in_d  = ram_addr_in_q;
    ram_data_in_d  = ram_data_in_q;
    pix_valid_d    = pix_valid_q;
    pix_data_d     = pix_data_q;
    frame_busy_d   = frame_busy_q;
    frame_done_d   = 1'b0;
    grant          = 1'b0;
    // The RAM samples the read address at the end of RDWAIT, so no write may follow it.
    wr_elig = wr_req && !wr_ack_q && (state_q != RDWAIT);

    case (state_q)
      IDLE: begin
        grant = wr_elig;
        if (frame_start) begin
          scan_addr_d  = '0;
          frame_busy_d = 1'b1;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (wr_elig && last_grant_q == LG_READ) begin
          grant        = 1'b1;
          last_grant_d = LG_WRITE;
        end else begin
          ram_addr_out_d = scan_addr_q;
          last_grant_d   = LG_READ;
          state_d        = RDWAIT;
        end
      end
      RDWAIT: state_d = LATCH;
      LATCH: begin
        grant       = wr_elig;
        pix_data_d  = ram_data_out;
        pix_valid_d = 1'b1;
        state_d     = PRESENT;
      end
      PRESENT: begin
        grant = wr_elig;
        if (pix_valid_q && pix_ready) begin
          pix_valid_d = 1'b0;
          if (scan_addr_q == LAST) begin
            frame_done_d = 1'b1;
            frame_busy_d = 1'b0;
            scan_addr_d  = '0;
            state_d      = IDLE;
          end else begin
            scan_addr_d = scan_addr_q + 1'b1;
            state_d     = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ack_d = grant;
    ram_rw_d = !grant;
    if (grant) begin
      ram_addr_in_d = wr_addr;
      ram_data_in_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      scan_addr_q    <= '0;
      last_grant_q   <= LG_READ;
      ram_rw_q       <= 1'b1;
      ram_addr_out_q <= '0;
      ram_addr_in_q  <= '0;
      ram_data_in_q  <= '0;
      wr_ack_q       <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= '0;
      frame_done_q   <= 1'b0;
      frame_busy_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      scan_addr_q    <= scan_addr_d;
      last_grant_q   <= last_grant_d;
      ram_rw_q       <= ram_rw_d;
      ram_addr_out_q <= ram_addr_out_d;
      ram_addr_in_q  <= ram_addr_in_d;
      ram_data_in_q  <= ram_data_in_d;
      wr_ack_q       <= wr_ack_d;
      pix_valid_q    <= pix_valid_d;
      pix_data_q     <= pix_data_d;
      frame_done_q   <= frame_done_d;
      frame_busy_q   <= frame_busy_d;
    end
  end

  assign wr_ack       = wr_ack_q;
  assign frame_busy   = frame_busy_q;
  assign frame_done   = frame_done_q;
  assign pix_data     = pix_data_q;
  assign pix_valid    = pix_valid_q;
  assign ram_rw       = ram_rw_q;
  assign ram_addr_out = ram_addr_out_q;
  assign ram_addr_in  = ram_addr_in_q;
  assign ram_data_in  = ram_data_in_q;

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Bench for pixel_ram_arbiter: behavioural RAM plus shadow memory, randomized
// CPU writes against frame scans, backpressure, NPIX=1 and mid-operation reset.
`timescale 1ns/1ps
module tb_pixel_ram_arbiter;
  localparam int AW = 6, DW = 24, NPIX = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, wr_ack, frame_start, frame_busy, frame_done;
  logic          pix_valid, pix_ready, ram_rw;
  logic [AW-1:0] wr_addr, ram_addr_out, ram_addr_in;
  logic [DW-1:0] wr_data, pix_data, ram_data_in, ram_data_out;

  logic          wr_ack1, frame_start1, frame_busy1, frame_done1, pix_valid1, ram_rw1;
  logic [AW-1:0] ram_addr_out1, ram_addr_in1;
  logic [DW-1:0] pix_data1, ram_data_in1, ram_data_out1;
  logic          wr_req1 = 1'b0, pix_ready1 = 1'b1;
  logic [AW-1:0] wr_addr1 = '0;
  logic [DW-1:0] wr_data1 = '0;

  logic [DW-1:0] mem     [NPIX];
  logic [DW-1:0] ref_mem [NPIX];

  int n_tests = 0, n_fail = 0;
  int deliv = 0, done_cnt = 0, cyc_n = 0, last_acc = 0;
  int acks = 0, acks_since = 0, auto_left = 0;
  bit thr_on = 0, arb_on = 0, auto_on = 0, prev_busy = 0;
  logic [5:0] di;

  always #5 clk = ~clk;

  pixel_ram_arbiter #(.AW(AW), .DW(DW), .NPIX(NPIX)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .frame_start(frame_start), .frame_busy(frame_busy),
    .frame_done(frame_done), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .ram_rw(ram_rw), .ram_addr_out(ram_addr_out),
    .ram_addr_in(ram_addr_in), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out));

  pixel_ram_arbiter #(.AW(AW), .DW(DW), .NPIX(1)) u1 (
    .clk(clk), .rst(rst), .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .wr_ack(wr_ack1), .frame_start(frame_start1), .frame_busy(frame_busy1),
    .frame_done(frame_done1), .pix_data(pix_data1), .pix_valid(pix_valid1),
    .pix_ready(pix_ready1), .ram_rw(ram_rw1), .ram_addr_out(ram_addr_out1),
    .ram_addr_in(ram_addr_in1), .ram_data_in(ram_data_in1), .ram_data_out(ram_data_out1));

  // Single-port RAM: writes when ram_rw=0, otherwise registered read.
  always @(posedge clk) begin
    if (!ram_rw) mem[ram_addr_in] <= ram_data_in;
    else         ram_data_out     <= mem[ram_addr_out];
  end

  always @(posedge clk) ram_data_out1 <= ram_rw1 ? {18'h2A5A5, ram_addr_out1} : 24'h0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Per-cycle monitor and auto writer, run at the falling edge.
  task automatic service();
    int a;
    if (!rst) begin
      if (!ram_rw) chk("rw_without_ack", {31'd0, wr_ack}, 1);
      if (auto_on && wr_ack) begin
        ref_mem[wr_addr] = wr_data;
        acks++;
        acks_since++;
        wr_req = 1'b0;
      end
      if (pix_valid && pix_ready) begin
        di = 6'(deliv);
        chk("pix", pix_data, ref_mem[di]);
        if (thr_on && deliv > 0) chk("period", cyc_n - last_acc, 4);
        if (arb_on && deliv > 0) chk("write_starved", {31'd0, acks_since > 0}, 1);
        acks_since = 0;
        last_acc   = cyc_n;
        deliv++;
      end
      if (frame_done) begin
        chk("done_busy", {31'd0, frame_busy}, 0);
        chk("busy_before_done", {31'd0, prev_busy}, 1);
        chk("npix", deliv, NPIX);
        done_cnt++;
        deliv = 0;
      end
      prev_busy = frame_busy;
      cyc_n++;
      if (auto_on && !wr_req && auto_left > 0) begin
        a = $urandom_range(0, NPIX - 1);
        // keep writes clear of pixels whose read may be imminent
        if (a >= deliv && a < deliv + 4) a = (a + 8) % NPIX;
        wr_addr = 6'(a);
        wr_data = 24'($urandom);
        wr_req  = 1'b1;
        auto_left--;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    service();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [23:0] d);
    int n = 0;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    do begin cyc(); n++; end while (!wr_ack && n < 8);
    chk("wr_ack", {31'd0, wr_ack}, 1);
    chk("wr_rw0", {31'd0, ram_rw}, 0);
    chk("wr_addr_in", {26'd0, ram_addr_in}, {26'd0, a});
    chk("wr_data_in", {8'd0, ram_data_in}, {8'd0, d});
    ref_mem[a] = d;
    wr_req = 1'b0;
    cyc();
    chk("wr_ack_pulse", {31'd0, wr_ack}, 0);
    chk("wr_rw1", {31'd0, ram_rw}, 1);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin cyc(); n++; end
    if (done_cnt == d0) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    int d0, n, n1, a0;
    logic [23:0] held, old, exp1;
    bit seen;
    exp1 = {18'h2A5A5, 6'd0};
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    frame_start = 1'b0; pix_ready = 1'b1; frame_start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rw", {31'd0, ram_rw}, 1);
    chk("rst_ack", {31'd0, wr_ack}, 0);
    chk("rst_valid", {31'd0, pix_valid}, 0);
    chk("rst_pix", {8'd0, pix_data}, 0);
    chk("rst_done_busy", {30'd0, frame_done, frame_busy}, 0);
    chk("rst_addrs", {20'd0, ram_addr_out, ram_addr_in}, 0);
    chk("rst_wdata", {8'd0, ram_data_in}, 0);
    chk("rst_u1", {1'b0, wr_ack1, ram_addr_in1, ram_data_in1}, 0);
    rst = 1'b0;
    cyc();

    do_write(6'd5, 24'hFF0000);
    cyc();
    chk("mem5", {8'd0, mem[5]}, 32'hFF0000);

    // preload and full-throughput scan
    for (int k = 0; k < NPIX; k++) do_write(6'(k), 24'(k * 24'h010101));
    thr_on = 1; pix_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    repeat (8) cyc();
    chk("done_once", done_cnt - d0, 1);

    // frame_start mid-frame must be ignored
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (deliv < 20 && n < 500) begin cyc(); n++; end
    pulse_start();
    wait_done(d0);
    repeat (20) cyc();
    chk("no_restart", done_cnt - d0, 1);
    chk("idle_busy", {31'd0, frame_busy}, 0);
    chk("idle_valid", {31'd0, pix_valid}, 0);
    thr_on = 0;

    // continuous random writes during a scan with random backpressure
    arb_on = 1; auto_on = 1; auto_left = 100000;
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end
    if (done_cnt == d0) chk("arb_timeout", 0, 1);
    arb_on = 0; auto_left = 0; pix_ready = 1'b1;
    n = 0;
    while (wr_req && n < 20) begin cyc(); n++; end
    chk("arb_drain", {31'd0, wr_req}, 0);
    auto_on = 0;
    cyc();

    // backpressure on pixel 3 with two writes granted meanwhile
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (deliv < 3 && n < 100) begin cyc(); n++; end
    pix_ready = 1'b0;
    n = 0;
    while (!pix_valid && n < 20) begin cyc(); n++; end
    held = pix_data;
    chk("bp_pix3", {8'd0, held}, {8'd0, ref_mem[3]});
    a0 = acks; auto_on = 1; auto_left = 2;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_valid", {31'd0, pix_valid}, 1);
      chk("bp_hold", {8'd0, pix_data}, {8'd0, held});
    end
    chk("bp_writes", acks - a0, 2);
    chk("bp_deliv", deliv, 3);
    auto_on = 0;
    pix_ready = 1'b1;
    wait_done(d0);

    // NPIX=1 instance
    seen = 0; n1 = 0;
    frame_start1 = 1'b1;
    cyc();
    frame_start1 = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (pix_valid1) begin
        n1++;
        chk("n1_pix", {8'd0, pix_data1}, {8'd0, exp1});
      end
      if (frame_done1) begin
        seen = 1;
        chk("n1_count", n1, 1);
        chk("n1_busy", {31'd0, frame_busy1}, 0);
      end
    end
    if (!seen) chk("n1_timeout", 0, 1);

    // reset in the write-grant cycle
    old = ref_mem[9];
    wr_addr = 6'd9; wr_data = ~old; wr_req = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!wr_ack && n < 8);
    chk("rstw_rw0", {31'd0, ram_rw}, 0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_rw", {31'd0, ram_rw}, 1);
    chk("rstw_ack", {31'd0, wr_ack}, 0);
    wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_mem", {8'd0, mem[9]}, {8'd0, old});
    cyc();

    // reset while presenting a pixel
    pix_ready = 1'b0; deliv = 0;
    pulse_start();
    n = 0;
    while (!pix_valid && n < 20) begin cyc(); n++; end
    chk("rstp_seen", {31'd0, pix_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstp_valid", {31'd0, pix_valid}, 0);
    chk("rstp_busy", {31'd0, frame_busy}, 0);
    chk("rstp_rw", {31'd0, ram_rw}, 1);
    chk("rstp_ack", {31'd0, wr_ack}, 0);
    @(posedge clk); #1;
    rst = 1'b0; deliv = 0; prev_busy = 0; pix_ready = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
